// File: rtl/chain_serializer.sv
// Byte-to-bitstream serializer: small byte FIFO feeding an MSB-first shifter
// that drives a downstream serial shift chain, with per-frame bit counting.
module chain_serializer #(
  parameter int unsigned LENGTH = 256,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  input  logic                      flush,
  output logic                      sr_din,
  output logic                      sr_clken,
  output logic                      busy,
  output logic [$clog2(LENGTH)-1:0] bit_count,
  output logic                      frame_done
);

  localparam int unsigned CW = $clog2(LENGTH);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(LENGTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nx;
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [7:0]  head;
  logic        empty, full, push, pop;
  logic [7:0]  hold, hold_nx;
  logic [2:0]  idx, idx_nx;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
  assign head  = mem[rd_ptr[AW-1:0]];
  assign push  = byte_valid && !full;

  assign byte_ready = !full;
  assign sr_clken   = (state == SHIFT);
  assign sr_din     = (state == SHIFT) && hold[7];
  assign busy       = (state == SHIFT) || !empty;
  assign frame_done = (state == SHIFT) && (bit_count == LAST_BIT);

  always_comb begin
    state_nx = state;
    hold_nx  = hold;
    idx_nx   = idx;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          hold_nx  = head;
          idx_nx   = 3'd7;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (idx != 3'd0) begin
          hold_nx = {hold[6:0], 1'b0};
          idx_nx  = idx - 3'd1;
        end else if (!empty) begin
          // Back-to-back reload keeps the serial stream gap-free.
          pop     = 1'b1;
          hold_nx = head;
          idx_nx  = 3'd7;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      idx       <= '0;
      bit_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      hold      <= '0;
      idx       <= '0;
      bit_count <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state <= state_nx;
      hold  <= hold_nx;
      idx   <= idx_nx;
      if (state == SHIFT) begin
        bit_count <= bit_count + CW'(1);
      end
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= byte_in;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule
